// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: operation classes, per-class op codes,
// memory access codes and multiply/divide FSM states.
package ex_stage_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned EX_OP_W    = 6;  // {class[2:0], op[2:0]}

  typedef enum logic [2:0] {
    EX_HIGH_SPECIAL = 3'd0,
    EX_HIGH_LOGIC   = 3'd1,
    EX_HIGH_SHIFT   = 3'd2,
    EX_HIGH_ARITH   = 3'd3,
    EX_HIGH_MULDIV  = 3'd4,
    EX_HIGH_MEM     = 3'd5
  } ex_class_e;

  localparam logic [2:0] OP_AND   = 3'd0, OP_OR    = 3'd1, OP_XOR  = 3'd2, OP_NOR  = 3'd3;
  localparam logic [2:0] OP_SLL   = 3'd0, OP_SRL   = 3'd1, OP_SRA  = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd0, OP_SUB   = 3'd1, OP_SLT  = 3'd2, OP_SLTU = 3'd3;
  localparam logic [2:0] OP_MULT  = 3'd0, OP_MULTU = 3'd1, OP_DIV  = 3'd2, OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4, OP_MFLO  = 3'd5, OP_MTHI = 3'd6, OP_MTLO = 3'd7;
  localparam logic [2:0] OP_LW    = 3'd0, OP_SW    = 3'd1;

  localparam logic [5:0] EXOP_NOP  = 6'o00;
  localparam logic [5:0] EXOP_AND  = 6'o10, EXOP_OR    = 6'o11, EXOP_XOR  = 6'o12, EXOP_NOR  = 6'o13;
  localparam logic [5:0] EXOP_SLL  = 6'o20, EXOP_SRL   = 6'o21, EXOP_SRA  = 6'o22;
  localparam logic [5:0] EXOP_ADD  = 6'o30, EXOP_SUB   = 6'o31, EXOP_SLT  = 6'o32, EXOP_SLTU = 6'o33;
  localparam logic [5:0] EXOP_MULT = 6'o40, EXOP_MULTU = 6'o41, EXOP_DIV  = 6'o42, EXOP_DIVU = 6'o43;
  localparam logic [5:0] EXOP_MFHI = 6'o44, EXOP_MFLO  = 6'o45, EXOP_MTHI = 6'o46, EXOP_MTLO = 6'o47;
  localparam logic [5:0] EXOP_LW   = 6'o50, EXOP_SW    = 6'o51;

  typedef enum logic [1:0] {
    MEMACC_NONE = 2'b00,
    MEMACC_LW   = 2'b01,
    MEMACC_SW   = 2'b10
  } memacc_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative 32-cycle multiply / restoring divide with HI/LO registers.
module muldiv_unit
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        signed_op;
  logic [31:0] mag_a, mag_b;
  logic [32:0] rsh, add_sum;
  logic [31:0] sub_diff;
  logic [63:0] prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    mag_a     = (signed_op && a_i[31]) ? -a_i : a_i;
    mag_b     = (signed_op && b_i[31]) ? -b_i : b_i;
    rsh       = acc_q[63:31];
    sub_diff  = rsh[31:0] - opnd_q;
    add_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    prod      = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;

    if (mthi_i) hi_d = a_i;
    if (mtlo_i) lo_d = a_i;

    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          neg_a_d  = signed_op & a_i[31];
          neg_b_d  = signed_op & b_i[31];
          is_div_d = (op_i == OP_DIV) || (op_i == OP_DIVU);
          div0_d   = (b_i == '0);
          acc_d    = {32'd0, mag_a};
          opnd_d   = mag_b;
          cnt_d    = '0;
          state_d  = MD_RUN;
        end
      end
      MD_RUN: begin
        // Divide keeps {remainder, quotient} in acc; multiply keeps {partial, multiplier}.
        if (is_div_q) begin
          if (rsh >= {1'b0, opnd_q}) acc_d = {sub_diff, acc_q[30:0], 1'b1};
          else                       acc_d = {rsh[31:0], acc_q[30:0], 1'b0};
        end else begin
          acc_d = {add_sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = MD_DONE;
      end
      MD_DONE: begin
        if (is_div_q) begin
          lo_d = div0_q ? '1 : ((neg_a_q ^ neg_b_q) ? -acc_q[31:0] : acc_q[31:0]);
          hi_d = neg_a_q ? -acc_q[63:32] : acc_q[63:32];
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy_o = ((state_q == MD_IDLE) && start_i) || (state_q == MD_RUN);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, combinational ALU, EX/MEM register and
// the iterative multiply/divide unit.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EX_OP_W-1:0]    i_exop,
  input  logic [WORD_W-1:0]     i_srcLeft,
  input  logic [WORD_W-1:0]     i_srcRight,
  input  logic [WORD_W-1:0]     i_offset,
  input  logic [REG_ADDR_W-1:0] i_dest,
  input  logic                  i_stall,
  output logic                  o_busy,
  output logic [REG_ADDR_W-1:0] o_exDest,
  output logic [WORD_W-1:0]     o_exResult,
  output logic                  o_exWriteEnable,
  output logic [REG_ADDR_W-1:0] o_memDest,
  output logic [WORD_W-1:0]     o_memResult,
  output logic                  o_memWriteEnable,
  output logic [1:0]            o_memAccess,
  output logic [WORD_W-1:0]     o_memAddr,
  output logic [WORD_W-1:0]     o_memStoreData
);

  logic [EX_OP_W-1:0]    op_q, op_d;
  logic [WORD_W-1:0]     left_q, left_d, right_q, right_d, offset_q, offset_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;

  logic [REG_ADDR_W-1:0] mem_dest_q, mem_dest_d;
  logic [WORD_W-1:0]     mem_result_q, mem_result_d;
  logic                  mem_we_q, mem_we_d;
  logic [1:0]            mem_acc_q, mem_acc_d;
  logic [WORD_W-1:0]     mem_addr_q, mem_addr_d, mem_sd_q, mem_sd_d;

  ex_class_e             cls;
  logic [2:0]            opc;
  logic [4:0]            shamt;
  logic [WORD_W-1:0]     ex_result, ex_addr, ex_sd, hi, lo;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  ex_we, ex_we_raw;
  memacc_e               ex_acc;
  logic                  md_start, md_mthi, md_mtlo, busy;

  assign cls   = ex_class_e'(op_q[5:3]);
  assign opc   = op_q[2:0];
  assign shamt = left_q[4:0];

  assign md_start = (cls == EX_HIGH_MULDIV) && !opc[2];
  assign md_mthi  = (cls == EX_HIGH_MULDIV) && (opc == OP_MTHI);
  assign md_mtlo  = (cls == EX_HIGH_MULDIV) && (opc == OP_MTLO);

  muldiv_unit u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .op_i    (opc),
    .a_i     (left_q),
    .b_i     (right_q),
    .mthi_i  (md_mthi),
    .mtlo_i  (md_mtlo),
    .busy_o  (busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  // Hold beats stall: a multi-cycle op must stay in EX until it completes.
  always_comb begin
    op_d     = op_q;
    left_d   = left_q;
    right_d  = right_q;
    offset_d = offset_q;
    dest_d   = dest_q;
    if (!busy) begin
      if (i_stall) begin
        op_d     = EXOP_NOP;
        left_d   = '0;
        right_d  = '0;
        offset_d = '0;
        dest_d   = '0;
      end else begin
        op_d     = i_exop;
        left_d   = i_srcLeft;
        right_d  = i_srcRight;
        offset_d = i_offset;
        dest_d   = i_dest;
      end
    end
  end

  always_comb begin
    ex_result = '0;
    ex_we_raw = 1'b0;
    ex_dest   = dest_q;
    ex_acc    = MEMACC_NONE;
    ex_addr   = '0;
    ex_sd     = '0;
    case (cls)
      EX_HIGH_LOGIC: begin
        ex_we_raw = 1'b1;
        case (opc)
          OP_AND:  ex_result = left_q & right_q;
          OP_OR:   ex_result = left_q | right_q;
          OP_XOR:  ex_result = left_q ^ right_q;
          OP_NOR:  ex_result = ~(left_q | right_q);
          default: ex_we_raw = 1'b0;
        endcase
      end
      EX_HIGH_SHIFT: begin
        ex_we_raw = 1'b1;
        case (opc)
          OP_SLL:  ex_result = right_q << shamt;
          OP_SRL:  ex_result = right_q >> shamt;
          OP_SRA:  ex_result = $signed(right_q) >>> shamt;
          default: ex_we_raw = 1'b0;
        endcase
      end
      EX_HIGH_ARITH: begin
        ex_we_raw = 1'b1;
        case (opc)
          OP_ADD:  ex_result = left_q + right_q;
          OP_SUB:  ex_result = left_q - right_q;
          OP_SLT:  ex_result = {31'd0, $signed(left_q) < $signed(right_q)};
          OP_SLTU: ex_result = {31'd0, left_q < right_q};
          default: ex_we_raw = 1'b0;
        endcase
      end
      EX_HIGH_MULDIV: begin
        if (opc == OP_MFHI) begin
          ex_result = hi;
          ex_we_raw = 1'b1;
        end else if (opc == OP_MFLO) begin
          ex_result = lo;
          ex_we_raw = 1'b1;
        end
      end
      EX_HIGH_MEM: begin
        ex_addr = left_q + offset_q;
        if (opc == OP_LW) begin
          ex_acc = MEMACC_LW;
        end else if (opc == OP_SW) begin
          ex_acc = MEMACC_SW;
          ex_sd  = right_q;
        end
      end
      default: ex_dest = '0;
    endcase
  end

  assign ex_we = ex_we_raw && (ex_dest != '0);

  always_comb begin
    mem_dest_d   = '0;
    mem_result_d = '0;
    mem_we_d     = 1'b0;
    mem_acc_d    = MEMACC_NONE;
    mem_addr_d   = '0;
    mem_sd_d     = '0;
    if (!busy) begin
      mem_dest_d   = ex_dest;
      mem_result_d = ex_result;
      mem_we_d     = ex_we || (ex_acc == MEMACC_LW);
      mem_acc_d    = ex_acc;
      mem_addr_d   = ex_addr;
      mem_sd_d     = ex_sd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= EXOP_NOP;
      left_q       <= '0;
      right_q      <= '0;
      offset_q     <= '0;
      dest_q       <= '0;
      mem_dest_q   <= '0;
      mem_result_q <= '0;
      mem_we_q     <= 1'b0;
      mem_acc_q    <= MEMACC_NONE;
      mem_addr_q   <= '0;
      mem_sd_q     <= '0;
    end else begin
      op_q         <= op_d;
      left_q       <= left_d;
      right_q      <= right_d;
      offset_q     <= offset_d;
      dest_q       <= dest_d;
      mem_dest_q   <= mem_dest_d;
      mem_result_q <= mem_result_d;
      mem_we_q     <= mem_we_d;
      mem_acc_q    <= mem_acc_d;
      mem_addr_q   <= mem_addr_d;
      mem_sd_q     <= mem_sd_d;
    end
  end

  assign o_busy           = busy;
  assign o_exDest         = ex_dest;
  assign o_exResult       = ex_result;
  assign o_exWriteEnable  = ex_we;
  assign o_memDest        = mem_dest_q;
  assign o_memResult      = mem_result_q;
  assign o_memWriteEnable = mem_we_q;
  assign o_memAccess      = mem_acc_q;
  assign o_memAddr        = mem_addr_q;
  assign o_memStoreData   = mem_sd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vectors plus random ops checked
// against an arithmetic reference model with its own HI/LO state.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  i_exop;
  logic [31:0] i_srcLeft, i_srcRight, i_offset;
  logic [4:0]  i_dest;
  logic        i_stall;
  logic        o_busy;
  logic [4:0]  o_exDest;
  logic [31:0] o_exResult;
  logic        o_exWriteEnable;
  logic [4:0]  o_memDest;
  logic [31:0] o_memResult;
  logic        o_memWriteEnable;
  logic [1:0]  o_memAccess;
  logic [31:0] o_memAddr;
  logic [31:0] o_memStoreData;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;
  logic [31:0] obs_hi, obs_lo;
  int unsigned busy_cycles;

  ex_stage dut (
    .clk              (clk),
    .rst              (rst),
    .i_exop           (i_exop),
    .i_srcLeft        (i_srcLeft),
    .i_srcRight       (i_srcRight),
    .i_offset         (i_offset),
    .i_dest           (i_dest),
    .i_stall          (i_stall),
    .o_busy           (o_busy),
    .o_exDest         (o_exDest),
    .o_exResult       (o_exResult),
    .o_exWriteEnable  (o_exWriteEnable),
    .o_memDest        (o_memDest),
    .o_memResult      (o_memResult),
    .o_memWriteEnable (o_memWriteEnable),
    .o_memAccess      (o_memAccess),
    .o_memAddr        (o_memAddr),
    .o_memStoreData   (o_memStoreData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] l, input logic [31:0] r,
                       input logic [31:0] off, input logic [4:0] d, input logic stall);
    i_exop = op; i_srcLeft = l; i_srcRight = r; i_offset = off; i_dest = d; i_stall = stall;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one single-cycle operation.
  task automatic model(input logic [5:0] op, input logic [31:0] l, input logic [31:0] r,
                       input logic [31:0] off, input logic [4:0] d,
                       output logic [31:0] res, output logic we, output logic [4:0] dst,
                       output logic [1:0] acc, output logic [31:0] addr, output logic [31:0] sd);
    int unsigned sh;
    sh = l % 32;
    res = 32'd0; we = 1'b0; dst = d; acc = 2'b00; addr = 32'd0; sd = 32'd0;
    case (op)
      EXOP_AND:  begin res = l & r;  we = 1'b1; end
      EXOP_OR:   begin res = l | r;  we = 1'b1; end
      EXOP_XOR:  begin res = l ^ r;  we = 1'b1; end
      EXOP_NOR:  begin res = ~(l | r); we = 1'b1; end
      EXOP_SLL:  begin res = r << sh; we = 1'b1; end
      EXOP_SRL:  begin res = r >> sh; we = 1'b1; end
      EXOP_SRA:  begin res = (r >> sh) | ((r[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0); we = 1'b1; end
      EXOP_ADD:  begin res = l + r;  we = 1'b1; end
      EXOP_SUB:  begin res = l + ~r + 32'd1; we = 1'b1; end
      EXOP_SLT:  begin res = (int'(l) < int'(r)) ? 32'd1 : 32'd0; we = 1'b1; end
      EXOP_SLTU: begin res = (longint'(l) < longint'(r)) ? 32'd1 : 32'd0; we = 1'b1; end
      EXOP_MFHI: begin res = m_hi; we = 1'b1; end
      EXOP_MFLO: begin res = m_lo; we = 1'b1; end
      EXOP_LW:   begin acc = 2'b01; addr = l + off; end
      EXOP_SW:   begin acc = 2'b10; addr = l + off; sd = r; end
      EXOP_NOP:  dst = 5'd0;
      default:   ;
    endcase
    if (d == 5'd0) we = 1'b0;
  endtask

  // One op through EX then EX/MEM; memory ops have no defined EX result.
  task automatic single(input string tag, input logic [5:0] op, input logic [31:0] l,
                        input logic [31:0] r, input logic [31:0] off, input logic [4:0] d);
    logic [31:0] res, addr, sd;
    logic        we, is_mem;
    logic [4:0]  dst;
    logic [1:0]  acc;
    model(op, l, r, off, d, res, we, dst, acc, addr, sd);
    is_mem = (op == EXOP_LW) || (op == EXOP_SW);
    drive(op, l, r, off, d, 1'b0);
    tick();
    if (!is_mem) chk({tag, " exResult"}, o_exResult, res);
    chk({tag, " exWE/dest/busy"}, {o_exWriteEnable, o_exDest, o_busy}, {we, dst, 1'b0});
    if (op == EXOP_MTHI) m_hi = l;
    if (op == EXOP_MTLO) m_lo = l;
    drive(EXOP_NOP, 0, 0, 0, 0, 1'b0);
    tick();
    chk({tag, " mem dest/we/acc/addr/sd"},
        {o_memDest, o_memWriteEnable, o_memAccess, o_memAddr, o_memStoreData},
        {dst, we | (op == EXOP_LW), acc, addr, sd});
    if (!is_mem) chk({tag, " memResult"}, o_memResult, res);
  endtask

  // Multiply/divide: busy duration, then MFHI and MFLO read back the new HI/LO.
  task automatic md(input string tag, input logic [5:0] op, input logic [31:0] l, input logic [31:0] r);
    logic [63:0] p, q, rm;
    case (op)
      EXOP_MULT:  begin p = longint'(int'(l)) * longint'(int'(r)); m_hi = p[63:32]; m_lo = p[31:0]; end
      EXOP_MULTU: begin p = {32'd0, l} * {32'd0, r}; m_hi = p[63:32]; m_lo = p[31:0]; end
      EXOP_DIV: begin
        if (r == 0) begin m_hi = l; m_lo = '1; end
        else begin
          q  = longint'(int'(l)) / longint'(int'(r));
          rm = longint'(int'(l)) % longint'(int'(r));
          m_lo = q[31:0]; m_hi = rm[31:0];
        end
      end
      default: begin
        if (r == 0) begin m_hi = l; m_lo = '1; end
        else begin m_lo = l / r; m_hi = l % r; end
      end
    endcase
    drive(op, l, r, 0, 0, 1'b0);
    tick();
    busy_cycles = 0;
    while (o_busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      drive(EXOP_OR, 32'hDEAD, 32'hBEEF, 0, 9, 1'b1);
      tick();
    end
    chk({tag, " busy cycles"}, busy_cycles, 33);
    drive(EXOP_MFHI, 0, 0, 0, 2, 1'b0);
    tick();
    obs_hi = o_exResult;
    chk({tag, " HI"}, obs_hi, m_hi);
    drive(EXOP_MFLO, 0, 0, 0, 3, 1'b0);
    tick();
    obs_lo = o_exResult;
    chk({tag, " LO"}, {o_exWriteEnable, obs_lo}, {1'b1, m_lo});
    drive(EXOP_NOP, 0, 0, 0, 0, 1'b0);
    tick();
  endtask

  logic [5:0] sc_ops [14] = '{EXOP_AND, EXOP_OR, EXOP_XOR, EXOP_NOR, EXOP_SLL, EXOP_SRL, EXOP_SRA,
                              EXOP_ADD, EXOP_SUB, EXOP_SLT, EXOP_SLTU, EXOP_LW, EXOP_SW, EXOP_NOP};
  logic [5:0] md_ops [4]  = '{EXOP_MULT, EXOP_MULTU, EXOP_DIV, EXOP_DIVU};

  initial begin
    logic [31:0] rr;
    rst = 1'b1;
    drive(EXOP_NOP, 0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs",
        {o_busy, o_exDest, o_exResult, o_exWriteEnable, o_memDest, o_memResult,
         o_memWriteEnable, o_memAccess, o_memAddr, o_memStoreData}, '0);
    rst = 1'b0;

    single("OR", EXOP_OR, 32'h0000_1234, 32'h0000_00FF, 0, 5'd5);
    chk("OR value", o_memResult, 32'h0000_12FF);
    single("SUB", EXOP_SUB, 32'd5, 32'd7, 0, 5'd6);
    chk("SUB value", o_memResult, 32'hFFFF_FFFE);
    single("SLT", EXOP_SLT, 32'hFFFF_FFFF, 32'd1, 0, 5'd7);
    chk("SLT value", o_memResult, 32'd1);
    single("SLTU", EXOP_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 5'd7);
    chk("SLTU value", o_memResult, 32'd0);
    single("SRA", EXOP_SRA, 32'd4, 32'h8000_0000, 0, 5'd8);
    chk("SRA value", o_memResult, 32'hF800_0000);
    single("ADD dest0", EXOP_ADD, 32'd1, 32'd2, 0, 5'd0);

    // Load: result not ready in EX, dest still visible for the decode stall.
    drive(EXOP_LW, 32'h100, 0, 32'd8, 5'd3, 1'b0);
    tick();
    chk("LW ex we/dest", {o_exWriteEnable, o_exDest}, {1'b0, 5'd3});
    drive(EXOP_NOP, 0, 0, 0, 0, 1'b0);
    tick();
    chk("LW mem acc/addr/we", {o_memAccess, o_memAddr, o_memWriteEnable}, {2'b01, 32'h108, 1'b1});

    md("MULT", EXOP_MULT, 32'hFFFF_FFFF, 32'd2);
    chk("MULT HI/LO", {obs_hi, obs_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    md("MULTU", EXOP_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("MULTU HI/LO", {obs_hi, obs_lo}, {32'h0000_0001, 32'hFFFF_FFFE});
    md("DIV", EXOP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("DIV HI/LO", {obs_hi, obs_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    md("DIVU0", EXOP_DIVU, 32'd7, 32'd0);
    chk("DIVU0 HI/LO", {obs_hi, obs_lo}, {32'h0000_0007, 32'hFFFF_FFFF});
    md("DIV0 neg", EXOP_DIV, 32'h8000_0005, 32'd0);

    single("MTHI", EXOP_MTHI, 32'hCAFE_0001, 0, 0, 5'd0);
    single("MTLO", EXOP_MTLO, 32'hCAFE_0002, 0, 0, 5'd0);
    single("MFHI", EXOP_MFHI, 0, 0, 0, 5'd4);
    single("MFLO", EXOP_MFLO, 0, 0, 0, 5'd4);

    for (int i = 0; i < 40; i++) begin
      single("rand sc", sc_ops[$urandom_range(0, 13)], $urandom, $urandom, $urandom,
             5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 3))
        0:       rr = 32'd0;
        1:       rr = 32'($urandom_range(1, 9));
        2:       rr = -32'($urandom_range(1, 9));
        default: rr = $urandom;
      endcase
      md("rand md", md_ops[$urandom_range(0, 3)], $urandom, rr);
    end

    // Stall pulse inserts a bubble even though decode offers a real op.
    drive(EXOP_OR, 32'd1, 32'd2, 0, 5'd7, 1'b1);
    tick();
    chk("stall bubble dest/we", {o_exDest, o_exWriteEnable}, {5'd0, 1'b0});

    // Reset in the middle of a divide.
    drive(EXOP_DIV, 32'd1000, 32'd3, 0, 0, 1'b0);
    tick();
    drive(EXOP_NOP, 0, 0, 0, 0, 1'b0);
    repeat (10) tick();
    chk("busy before abort", o_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort outputs",
        {o_busy, o_exDest, o_exResult, o_exWriteEnable, o_memDest, o_memResult,
         o_memWriteEnable, o_memAccess, o_memAddr, o_memStoreData}, '0);
    m_hi = '0;
    m_lo = '0;
    tick();
    rst = 1'b0;
    single("MFHI after abort", EXOP_MFHI, 0, 0, 0, 5'd2);
    single("MFLO after abort", EXOP_MFLO, 0, 0, 0, 5'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage toy MIPS pipeline, sitting between the decode stage and the memory stage. It holds the ID/EX pipeline register, evaluates the operation class carried in `exop`, and runs an iterative 32-cycle multiply/divide unit with HI/LO registers. It returns forwarding and readiness information (`exDest`/`exResult`/`exWriteEnable`, `memDest`/`memResult`) to the decode stage, and drives the EX/MEM pipeline register toward memory.

## Interface
Parameters:
- none. Widths come from `define.v`: `WORD_BUS` 32, `REG_ADDR_BUS` 5, `EX_OP_BUS` = {class, op}.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_exop` in `EX_OP_BUS`: operation from decode.
- `i_srcLeft` in 32: left operand, already forwarded.
- `i_srcRight` in 32: right operand, already forwarded.
- `i_offset` in 32: memory offset.
- `i_dest` in 5: destination register.
- `i_stall` in 1: decode stall; this cycle's decode output is not captured.
- `o_busy` out 1: multiply/divide occupying EX; upstream must hold IF/ID.
- `o_exDest` out 5: combinational; dest of the op currently in EX.
- `o_exResult` out 32: combinational result.
- `o_exWriteEnable` out 1: result valid this cycle. Low means the result is not ready, and decode stalls on a match.
- `o_memDest` out 5: registered EX/MEM dest.
- `o_memResult` out 32: registered EX/MEM result.
- `o_memWriteEnable` out 1: registered EX/MEM write enable.
- `o_memAccess` out 2: 00 none, 01 load word, 10 store word.
- `o_memAddr` out 32: load/store address.
- `o_memStoreData` out 32: store data.

## Operation
- ID/EX register, evaluated in priority order on each clock edge:
  - if `o_busy`, hold;
  - else if `i_stall`, load a bubble (SPECIAL_NOP, dest 0, operands 0);
  - else capture the decode outputs.
- Classes:
  - SPECIAL: NOP. Dest 0, write enable 0.
  - LOGIC: AND, OR, XOR, NOR on left/right.
  - SHIFT: SLL, SRL, SRA. The value is right; the shift amount is left[4:0].
  - ARITH: ADD, SUB (wrap, no overflow trap), SLT (signed), SLTU (unsigned), each yielding 0 or 1.
  - MULDIV: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
  - MEM: LW, SW. Address = left + offset; store data = right.
- `o_exWriteEnable`:
  - 1 for LOGIC, SHIFT, ARITH, MFHI and MFLO when dest ≠ 0;
  - 0 for LW, since the value is not ready. Dest is still driven, so decode stalls.
- Mult/div FSM: IDLE → RUN (32 iterations) → DONE → IDLE.
  - Operand signs are converted to magnitudes in IDLE.
  - Multiply: shift-add, one bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - Result signs are corrected in DONE: quotient sign = XOR of operand signs; remainder sign = dividend sign.
  - DONE writes HI/LO.
- Result placement: multiply writes HI = product[63:32], LO = product[31:0]. Divide writes LO = quotient, HI = remainder.
- Divide by zero: LO = 0xFFFFFFFF, HI = dividend. No exception.
- MTHI and MTLO write HI or LO from the left operand at the clock edge.
- MFHI and MFLO read the current HI or LO.
- EX/MEM register captures the EX results every cycle. Its write enable becomes 1 for LW, because memory supplies the data. During `o_busy` it loads a bubble.

## Timing
- Reset: all pipeline registers are cleared and every output driven 0. FSM goes to IDLE; HI and LO are cleared. A reset mid-operation aborts any multiply/divide in flight immediately.
- Single-cycle classes: the result is visible on `o_exResult` in the cycle the op sits in EX, and on `o_mem*` one edge later.
- MULT/DIV latency: 34 cycles in EX.
  - Cycle 0 (IDLE, start): `o_busy` = 1.
  - Cycles 1–32 (RUN): `o_busy` = 1.
  - Cycle 33 (DONE): `o_busy` = 0, and HI/LO update at the closing edge.
  - An MFHI in the next cycle sees the new value.
- `i_stall` while `o_busy` = 1 is ignored; hold takes priority.
- Back-to-back MULDIV ops: the second starts in IDLE in the cycle after DONE.

## Structure
- `define.v` gains:
  - the `EX_HIGH_*` class codes and per-class op codes;
  - `MEMACC_*` encodings;
  - FSM state codes `MD_IDLE`, `MD_RUN`, `MD_DONE`.
- Sub-module `muldiv_unit`: FSM, 5-bit iteration counter, 64-bit accumulator, HI/LO registers, start/done handshake. `ex_stage` holds the pipeline registers and the combinational ALU.

## Test plan
- OR with left 0x00001234, right 0x000000FF, dest 5 → `o_exResult` 0x000012FF and `o_exWriteEnable` 1 in the same cycle; `o_memResult` 0x000012FF next cycle.
- SUB 5−7 → 0xFFFFFFFE. SLT with left 0xFFFFFFFF, right 1 → 1. SLTU on the same operands → 0. SRA of 0x80000000 by 4 → 0xF8000000.
- MULT 0xFFFFFFFF × 2 → `o_busy` high for exactly 33 cycles; HI 0xFFFFFFFF, LO 0xFFFFFFFE. MULTU on the same operands → HI 0x00000001, LO 0xFFFFFFFE.
- DIV −7/2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. DIVU 7/0 → LO 0xFFFFFFFF, HI 0x00000007. MFLO immediately after → 0xFFFFFFFF.
- LW with left 0x100 and offset 8, dest 3 → `o_exWriteEnable` 0, `o_exDest` 3. Next cycle: `o_memAccess` 01, `o_memAddr` 0x108.
- Assert `rst` in cycle 10 of a DIV → all outputs 0 and `o_busy` 0 immediately; HI/LO 0. `i_stall` pulse → a NOP bubble enters EX, with `o_exDest` 0.
